// File: rtl/alu_seq16_pkg.sv
// Shared definitions for the two-beat 16-bit ALU sequencer.
// Contents: 8-bit ALU opcodes, sequencer state type, beat-order helper.
// No ports; imported by alu_seq16 and alu_seq16_alu.
package alu_seq16_pkg;

  // 8-bit ALU opcodes. Encodings 3'd6 and 3'd7 are unassigned; the ALU
  // returns zero for them.
  localparam logic [2:0] ALU_OR  = 3'd0;
  localparam logic [2:0] ALU_AND = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_ADD = 3'd3;
  localparam logic [2:0] ALU_SL  = 3'd4;
  localparam logic [2:0] ALU_SR  = 3'd5;

  // Sequencer states: waiting, first byte, second byte, result held.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Right shifts move bits downward, so the carry must travel from the high
  // byte into the low byte: process the high byte first for SR only.
  function automatic logic hi_byte_first(input logic [2:0] op);
    return (op == ALU_SR);
  endfunction

endpackage

// File: rtl/alu_seq16_alu.sv
// 8-bit 6502-style ALU: OR/AND/XOR/ADD/SL/SR on one byte, purely combinational.
// Ports: op (opcode), a/b (byte operands), ci (carry or shift-in bit),
//        out (byte result), co (carry or shifted-out bit), vo (signed overflow, ADD only).
module alu_seq16_alu
  import alu_seq16_pkg::*;
(
  input  logic [2:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       ci,
  output logic [7:0] out,
  output logic       co,
  output logic       vo
);

  logic [8:0] sum;

  always_comb begin
    sum = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    out = 8'h00;
    co  = 1'b0;
    vo  = 1'b0;
    case (op)
      ALU_OR:  out = a | b;
      ALU_AND: out = a & b;
      ALU_XOR: out = a ^ b;
      ALU_ADD: begin
        out = sum[7:0];
        co  = sum[8];
        // Overflow: both operands share a sign the result does not.
        vo  = (a[7] == b[7]) && (sum[7] != a[7]);
      end
      ALU_SL: begin
        out = {a[6:0], ci};
        co  = a[7];
      end
      ALU_SR: begin
        out = {ci, a[7:1]};
        co  = a[0];
      end
      default: begin
        out = 8'h00;
        co  = 1'b0;
        vo  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq16.sv
// Two-beat 16-bit ALU sequencer around one 8-bit ALU, with carry chained between beats
// and an optional single-beat ADD when the high byte cannot change (no page cross).
// Ports: req_* valid/ready request (op, a, b, ci, invb, skip); rsp_* valid/ready result
//        (out, c, v, z, n, beats). One op in flight; the result is held until rsp_ready.
module alu_seq16
  import alu_seq16_pkg::*;
#(
  parameter bit SKIP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic        req_ci,
  input  logic        req_invb,
  input  logic        req_skip,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_out,
  output logic        rsp_c,
  output logic        rsp_v,
  output logic        rsp_z,
  output logic        rsp_n,
  output logic [1:0]  rsp_beats
);

  seq_state_t  state_q, state_d;

  // Latched request. b_q already holds ~b for subtract.
  logic [2:0]  op_q, op_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic        ci_q, ci_d;
  logic        skip_q, skip_d;

  // First-beat byte result and its carry, consumed by the second beat.
  logic [7:0]  byte_q, byte_d;
  logic        carry_q, carry_d;

  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_out_q, rsp_out_d;
  logic        rsp_c_q, rsp_c_d;
  logic        rsp_v_q, rsp_v_d;
  logic        rsp_z_q, rsp_z_d;
  logic        rsp_n_q, rsp_n_d;
  logic [1:0]  rsp_beats_q, rsp_beats_d;

  logic        second_beat;
  logic        sel_hi;
  logic [7:0]  alu_a, alu_b;
  logic        alu_ci;
  logic [7:0]  alu_out;
  logic        alu_co;
  logic        alu_vo;
  logic [15:0] full_res;
  logic [15:0] skip_res;

  // Byte steering: the ALU sees the high byte when exactly one of
  // "this op goes high-first" and "this is the second beat" holds.
  always_comb begin
    second_beat = (state_q == BEAT2);
    sel_hi      = hi_byte_first(op_q) ^ second_beat;
    alu_a       = sel_hi ? a_q[15:8] : a_q[7:0];
    alu_b       = sel_hi ? b_q[15:8] : b_q[7:0];
    alu_ci      = second_beat ? carry_q : ci_q;
  end

  alu_seq16_alu u_alu (
    .op  (op_q),
    .a   (alu_a),
    .b   (alu_b),
    .ci  (alu_ci),
    .out (alu_out),
    .co  (alu_co),
    .vo  (alu_vo)
  );

  // Result assembly for the two-beat and the skipped paths.
  always_comb begin
    full_res = hi_byte_first(op_q) ? {byte_q, alu_out} : {alu_out, byte_q};
    // With no low-byte carry and a zero high byte of b, the high byte of
    // the sum is just a's high byte.
    skip_res = {a_q[15:8], alu_out};
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    ci_d        = ci_q;
    skip_d      = skip_q;
    byte_d      = byte_q;
    carry_d     = carry_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_out_d   = rsp_out_q;
    rsp_c_d     = rsp_c_q;
    rsp_v_d     = rsp_v_q;
    rsp_z_d     = rsp_z_q;
    rsp_n_d     = rsp_n_q;
    rsp_beats_d = rsp_beats_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          state_d     = BEAT1;
          req_ready_d = 1'b0;
          op_d        = req_op;
          a_d         = req_a;
          b_d         = (req_invb && (req_op == ALU_ADD)) ? ~req_b : req_b;
          ci_d        = req_ci;
          // Qualify the skip hint once here so the beat logic only needs
          // the low-byte carry to decide.
          skip_d      = req_skip && (req_op == ALU_ADD) && !req_invb &&
                        (req_b[15:8] == 8'h00);
        end
      end

      BEAT1: begin
        byte_d  = alu_out;
        carry_d = alu_co;
        if (SKIP_EN && skip_q && !alu_co) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
          rsp_out_d   = skip_res;
          rsp_c_d     = 1'b0;
          rsp_v_d     = 1'b0;
          rsp_z_d     = (skip_res == 16'h0000);
          rsp_n_d     = skip_res[15];
          rsp_beats_d = 2'd1;
        end else begin
          state_d = BEAT2;
        end
      end

      BEAT2: begin
        state_d     = DONE;
        rsp_valid_d = 1'b1;
        rsp_out_d   = full_res;
        rsp_c_d     = alu_co;
        // For ADD the second beat is the high byte, so its overflow is the
        // 16-bit signed overflow.
        rsp_v_d     = (op_q == ALU_ADD) ? alu_vo : 1'b0;
        rsp_z_d     = (full_res == 16'h0000);
        rsp_n_d     = full_res[15];
        rsp_beats_d = 2'd2;
      end

      DONE: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= 3'd0;
      a_q         <= 16'h0000;
      b_q         <= 16'h0000;
      ci_q        <= 1'b0;
      skip_q      <= 1'b0;
      byte_q      <= 8'h00;
      carry_q     <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_out_q   <= 16'h0000;
      rsp_c_q     <= 1'b0;
      rsp_v_q     <= 1'b0;
      rsp_z_q     <= 1'b0;
      rsp_n_q     <= 1'b0;
      rsp_beats_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ci_q        <= ci_d;
      skip_q      <= skip_d;
      byte_q      <= byte_d;
      carry_q     <= carry_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_out_q   <= rsp_out_d;
      rsp_c_q     <= rsp_c_d;
      rsp_v_q     <= rsp_v_d;
      rsp_z_q     <= rsp_z_d;
      rsp_n_q     <= rsp_n_d;
      rsp_beats_q <= rsp_beats_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_v     = rsp_v_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_n     = rsp_n_q;
  assign rsp_beats = rsp_beats_q;

endmodule

// File: tb/tb_alu_seq16.sv
module tb_alu_seq16;
  import alu_seq16_pkg::*;

  typedef struct packed {
    logic [15:0] out;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
    logic [1:0]  beats;
  } res_t;

  typedef struct {
    res_t r;
    int   acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        req_ci;
  logic        req_invb;
  logic        req_skip;
  logic        req_ready [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [15:0] rsp_out   [2];
  logic        rsp_c     [2];
  logic        rsp_v     [2];
  logic        rsp_z     [2];
  logic        rsp_n     [2];
  logic [1:0]  rsp_beats [2];

  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;
  exp_t expq [2][$];
  bit   seen [2];

  always #5 clk = ~clk;

  // Instance 0 honours the skip hint, instance 1 never skips; both see the same requests.
  alu_seq16 #(.SKIP_EN(1'b1)) dut_skip (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready[0]), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ci(req_ci), .req_invb(req_invb), .req_skip(req_skip),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_out(rsp_out[0]),
    .rsp_c(rsp_c[0]), .rsp_v(rsp_v[0]), .rsp_z(rsp_z[0]), .rsp_n(rsp_n[0]),
    .rsp_beats(rsp_beats[0])
  );

  alu_seq16 #(.SKIP_EN(1'b0)) dut_noskip (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready[1]), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ci(req_ci), .req_invb(req_invb), .req_skip(req_skip),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_out(rsp_out[1]),
    .rsp_c(rsp_c[1]), .rsp_v(rsp_v[1]), .rsp_z(rsp_z[1]), .rsp_n(rsp_n[1]),
    .rsp_beats(rsp_beats[1])
  );

  function automatic res_t mk(input logic [15:0] out, input logic c, input logic v,
                              input logic z, input logic n, input logic [1:0] beats);
    res_t r;
    r.out = out; r.c = c; r.v = v; r.z = z; r.n = n; r.beats = beats;
    return r;
  endfunction

  // Whole-word reference: 16-bit results straight from arithmetic on the operands.
  function automatic res_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                                 input logic ci, input logic invb, input logic skip,
                                 input logic skip_en);
    res_t        r;
    logic [16:0] s;
    logic [15:0] bb;
    logic [8:0]  lo;
    r = '0;
    r.beats = 2'd2;
    case (op)
      ALU_ADD: begin
        bb = invb ? ~b : b;
        s = {1'b0, a} + {1'b0, bb} + {16'd0, ci};
        r.out = s[15:0];
        r.c = s[16];
        r.v = (a[15] == bb[15]) && (s[15] != a[15]);
        lo = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, ci};
        if (skip_en && skip && !invb && (b[15:8] == 8'h00) && !lo[8]) r.beats = 2'd1;
      end
      ALU_AND: r.out = a & b;
      ALU_OR:  r.out = a | b;
      ALU_XOR: r.out = a ^ b;
      ALU_SL:  {r.c, r.out} = {a, ci};
      ALU_SR:  {r.out, r.c} = {ci, a};
      default: r.out = 16'h0000;
    endcase
    r.z = (r.out == 16'h0000);
    r.n = r.out[15];
    return r;
  endfunction

  function automatic res_t dut_res(input int i);
    return mk(rsp_out[i], rsp_c[i], rsp_v[i], rsp_z[i], rsp_n[i], rsp_beats[i]);
  endfunction

  task automatic chk_res(input string name, input res_t got, input res_t exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got out=%h c=%b v=%b z=%b n=%b beats=%0d, expected out=%h c=%b v=%b z=%b n=%b beats=%0d",
               name, got.out, got.c, got.v, got.z, got.n, got.beats,
               exp.out, exp.c, exp.v, exp.z, exp.n, exp.beats);
    end
  endtask

  task automatic chk_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Accept / handshake tracking on the clock edge.
  always @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (req_valid && req_ready[i]) begin
          exp_t e;
          e.r   = model(req_op, req_a, req_b, req_ci, req_invb, req_skip, (i == 0));
          e.acc = cyc;
          expq[i].push_back(e);
        end
        if (rsp_valid[i] && rsp_ready[i] && (expq[i].size() > 0)) begin
          void'(expq[i].pop_front());
          seen[i] = 1'b0;
        end
      end
    end
    cyc = cyc + 1;
  end

  // Every falling edge: ready matches occupancy, any held result matches the model,
  // and the first sighting of a result lands the expected number of edges after accept.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        chk_bit($sformatf("req_ready[%0d]", i), req_ready[i], (expq[i].size() == 0));
        if (rsp_valid[i]) begin
          if (expq[i].size() == 0) begin
            checks++;
            fails++;
            $display("FAIL spurious_rsp[%0d]: rsp_valid=1 with no op in flight", i);
          end else begin
            chk_res($sformatf("model_rsp[%0d]", i), dut_res(i), expq[i][0].r);
            if (!seen[i]) begin
              seen[i] = 1'b1;
              chk_int($sformatf("latency[%0d]", i), cyc - expq[i][0].acc,
                      (expq[i][0].r.beats == 2'd1) ? 2 : 3);
            end
          end
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic invb, input logic skip);
    int n;
    n = 0;
    while (!(req_ready[0] && req_ready[1]) && (n < 40)) begin
      @(negedge clk);
      n++;
    end
    if (!(req_ready[0] && req_ready[1])) timeout_fail("issue_wait_ready");
    req_op = op; req_a = a; req_b = b; req_ci = ci; req_invb = invb; req_skip = skip;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input bit rnd);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      if (rnd) begin
        rsp_ready[0] = ($urandom_range(0, 3) != 0);
        rsp_ready[1] = ($urandom_range(0, 3) != 0);
      end
      n++;
    end while (!((expq[0].size() == 0) && (expq[1].size() == 0)) && (n < 60));
    if (!((expq[0].size() == 0) && (expq[1].size() == 0))) timeout_fail("wait_idle");
  endtask

  task automatic run_dir(input string name, input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic ci, input logic invb,
                         input logic skip, input res_t exp0, input res_t exp1);
    bit got [2];
    int n;
    got[0] = 1'b0;
    got[1] = 1'b0;
    n = 0;
    rsp_ready[0] = 1'b1;
    rsp_ready[1] = 1'b1;
    issue(op, a, b, ci, invb, skip);
    while (!(got[0] && got[1]) && (n < 12)) begin
      for (int i = 0; i < 2; i++) begin
        if (rsp_valid[i] && !got[i]) begin
          got[i] = 1'b1;
          chk_res($sformatf("%s[%0d]", name, i), dut_res(i), (i == 0) ? exp0 : exp1);
        end
      end
      if (!(got[0] && got[1])) begin
        @(negedge clk);
        n++;
      end
    end
    if (!(got[0] && got[1])) timeout_fail(name);
    wait_idle(1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    res_t        snap [2];
    int          n;

    req_valid = 1'b0; req_op = 3'd0; req_a = 16'h0; req_b = 16'h0;
    req_ci = 1'b0; req_invb = 1'b0; req_skip = 1'b0;
    rsp_ready[0] = 1'b1;
    rsp_ready[1] = 1'b1;
    seen[0] = 1'b0;
    seen[1] = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk_bit($sformatf("reset_req_ready[%0d]", i), req_ready[i], 1'b1);
      chk_bit($sformatf("reset_rsp_valid[%0d]", i), rsp_valid[i], 1'b0);
      chk_res($sformatf("reset_rsp[%0d]", i), dut_res(i), mk(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    end
    rst_n = 1'b1;

    // Hand-computed anchors for the reference model.
    chk_res("pin_add_carry", model(ALU_ADD, 16'h12FF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1),
            mk(16'h1300, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2));
    chk_res("pin_add_skip", model(ALU_ADD, 16'h1234, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b1),
            mk(16'h1244, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1));
    chk_res("pin_add_noskip", model(ALU_ADD, 16'h1234, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b0),
            mk(16'h1244, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2));
    chk_res("pin_sub_ovf", model(ALU_ADD, 16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1),
            mk(16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2));
    chk_res("pin_sr", model(ALU_SR, 16'h0101, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1),
            mk(16'h8080, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2));
    chk_res("pin_sl", model(ALU_SL, 16'h8001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1),
            mk(16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2));

    // Directed cases through both instances.
    run_dir("add_carry", ALU_ADD, 16'h12FF, 16'h0001, 1'b0, 1'b0, 1'b1,
            mk(16'h1300, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2), mk(16'h1300, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2));
    run_dir("add_skip", ALU_ADD, 16'h1234, 16'h0010, 1'b0, 1'b0, 1'b1,
            mk(16'h1244, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1), mk(16'h1244, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2));
    run_dir("sub_ovf", ALU_ADD, 16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1,
            mk(16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2), mk(16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd2));
    run_dir("sub_zero", ALU_ADD, 16'h0005, 16'h0005, 1'b1, 1'b1, 1'b0,
            mk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2), mk(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 2'd2));
    run_dir("sr", ALU_SR, 16'h0101, 16'h0000, 1'b1, 1'b0, 1'b0,
            mk(16'h8080, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2), mk(16'h8080, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2));
    run_dir("sl", ALU_SL, 16'h8001, 16'h0000, 1'b0, 1'b0, 1'b0,
            mk(16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2), mk(16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2));
    run_dir("xor", ALU_XOR, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0,
            mk(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2), mk(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2));
    run_dir("undef_op", 3'd7, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b1,
            mk(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2), mk(16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2));

    // Hold the result for 5 cycles with a competing request present.
    rsp_ready[0] = 1'b0;
    rsp_ready[1] = 1'b0;
    issue(ALU_ADD, 16'h12FF, 16'h0001, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!(rsp_valid[0] && rsp_valid[1]) && (n < 10)) begin
      @(negedge clk);
      n++;
    end
    if (!(rsp_valid[0] && rsp_valid[1])) timeout_fail("hold_wait_rsp");
    snap[0] = dut_res(0);
    snap[1] = dut_res(1);
    req_op = ALU_OR; req_a = 16'hDEAD; req_b = 16'hBEEF; req_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk_res($sformatf("hold_stable[%0d]", i), dut_res(i), snap[i]);
        chk_bit($sformatf("hold_valid[%0d]", i), rsp_valid[i], 1'b1);
        chk_bit($sformatf("hold_req_ready[%0d]", i), req_ready[i], 1'b0);
      end
    end
    req_valid = 1'b0;
    rsp_ready[0] = 1'b1;
    rsp_ready[1] = 1'b1;
    wait_idle(1'b0);

    // Reset while the next op is in its second beat.
    issue(ALU_XOR, 16'hA5A5, 16'h0F0F, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk_bit($sformatf("rst_mid_valid[%0d]", i), rsp_valid[i], 1'b0);
      chk_bit($sformatf("rst_mid_req_ready[%0d]", i), req_ready[i], 1'b1);
      chk_res($sformatf("rst_mid_rsp[%0d]", i), dut_res(i), mk(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
      expq[i].delete();
      seen[i] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        chk_bit($sformatf("post_rst_quiet[%0d]", i), rsp_valid[i], 1'b0);
    end
    run_dir("post_rst_add", ALU_ADD, 16'h00F0, 16'h0020, 1'b0, 1'b0, 1'b1,
            mk(16'h0110, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2), mk(16'h0110, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2));

    // Randomized ops with random consumer backpressure, checked by the model.
    for (int k = 0; k < 300; k++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) op = ALU_ADD;
      a = 16'($urandom);
      if ($urandom_range(0, 1) == 1) b = 16'($urandom);
      else b = 16'($urandom_range(0, 255));
      issue(op, a, b, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 1)));
      wait_idle(1'b1);
    end
    rsp_ready[0] = 1'b1;
    rsp_ready[1] = 1'b1;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
